sw_debouncer: RTL and testbench
===============================

# sw_debouncer

Synchronises and debounces the raw slide-switch bus before it reaches the enable gate and priority encoder in the top level. Each bit passes through a two-flop synchroniser and a per-bit stability counter. A bit's output changes only after its synchronised input has differed from the current output for STABLE_CYCLES consecutive clocks. The block also emits a one-cycle `changed` pulse and, optionally, per-bit edge pulses.

## Interface
- WIDTH, default 8: number of switch bits.
- STABLE_CYCLES, default 500000 (10 ms at 50 MHz): consecutive mismatching clocks required to accept a new level. Legal range is ≥1.
- Clock and reset: one clock; reset is synchronous and active-high; ports `clk` and `rst`.
- clk  input  1  system clock, all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- sw_in  input  WIDTH  raw asynchronous switch levels.
- sw_out  output  WIDTH  debounced levels; feeds the enable gate.
- changed  output  1  one-cycle pulse when any bit of sw_out updates.
- rise  output  WIDTH  one-cycle pulse per bit on an accepted 0→1 transition.
- fall  output  WIDTH  one-cycle pulse per bit on an accepted 1→0 transition.

## Operation
- Synchroniser: sync0 <= sw_in, then sync1 <= sync0.
- Per-bit counter cnt[i], width max(1, $clog2(STABLE_CYCLES)).
- If sync1[i] == sw_out[i]: cnt[i] <= 0 (any glitch shorter than the window is discarded).
- Else if cnt[i] == STABLE_CYCLES-1: sw_out[i] <= sync1[i] and cnt[i] <= 0.
- Else: cnt[i] <= cnt[i]+1.
- The counter never exceeds STABLE_CYCLES-1, so no wrap is possible.
- Bits are fully independent. Simultaneous updates on several bits in the same cycle produce a single `changed` pulse, and each updating bit gets its own rise or fall pulse.
- changed, rise and fall are registered and assert in the same cycle sw_out takes its new value. They deassert the next cycle unless another update occurs.
- A bit that toggles back before acceptance produces no output activity.

## Timing
- Reset values: sync0, sync1, sw_out, all cnt, changed, rise and fall are all 0.
- Latency: a clean level change on sw_in first sampled at edge k appears on sw_out after edge k+STABLE_CYCLES+1.
  - With STABLE_CYCLES=1 this is k+2, i.e. pure synchroniser delay.
- Reset mid-count: counters and outputs clear on the reset edge. After release, switches held high are re-debounced from scratch and produce rise pulses after STABLE_CYCLES+2 clocks.
- Reset dominates any simultaneous update.

## Configuration
- SW_DEBOUNCER_EDGE_EN defined: rise and fall are generated as described.
- Not defined: rise and fall ports remain present but are tied to 0, and the edge registers are not synthesised. sw_out and changed behave identically in both builds.

## Structure
- Package `sw_debounce_pkg`:
  - DEFAULT_STABLE_CYCLES (500000).
  - SIM_STABLE_CYCLES (4).
  - A `function` computing the counter width.
- Sub-module `debounce_bit`:
  - One bit of counter plus output register.
  - Ports: clk, rst, in (from sync1), out, upd (1-cycle update strobe), rise, fall.
  - Instantiated WIDTH times by generate.
- Top level holds the shared synchroniser and the OR-reduction of the upd strobes into `changed`.

## Test plan
- STABLE_CYCLES=4. Reset, then sw_in=8'h00 held → sw_out=8'h00 and changed, rise, fall all 0 for 20 cycles.
- sw_in 8'h00→8'h80 at edge k → sw_out=8'h80 after edge k+5; changed=1 and rise=8'h80 for exactly that cycle.
- Bit 0 pulses high for 3 clocks then returns low → sw_out stays 8'h00 and no pulses.
- sw_in 8'h00→8'h81 in one cycle → both bits update on the same edge; changed pulses once; rise=8'h81.
- sw_out=8'hFF, then rst asserted for 1 cycle with sw_in held 8'hFF → sw_out=8'h00 on the reset edge; back to 8'hFF 6 clocks after release with rise=8'hFF.
- Build without SW_DEBOUNCER_EDGE_EN, transition 8'hFF→8'h00 → sw_out=8'h00 and changed pulses; rise and fall stay 0.

Source files
------------

// File: rtl/sw_debounce_pkg.sv
// Shared constants and the stability-counter width helper for the switch debouncer.
package sw_debounce_pkg;

    localparam int unsigned DEFAULT_STABLE_CYCLES = 500000;
    localparam int unsigned SIM_STABLE_CYCLES     = 4;

    // A window of one cycle still needs a 1-bit counter to stay well-formed.
    function automatic int unsigned cnt_width(input int unsigned stable_cycles);
        int unsigned w;
        w = $clog2(stable_cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One debounced switch bit: stability counter, output register and update/edge strobes.
// Edge strobes exist only when SW_DEBOUNCER_EDGE_EN is defined; otherwise they are tied low.
module debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out,
    output logic upd,
    output logic rise,
    output logic fall
);

    localparam int unsigned CntW = cnt_width(STABLE_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            out_q, out_d;
    logic            upd_q, upd_d;

    // Any sample that agrees with the output restarts the window.
    always_comb begin
        cnt_d = cnt_q;
        out_d = out_q;
        upd_d = 1'b0;
        if (in == out_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            cnt_d = '0;
            out_d = in;
            upd_d = 1'b1;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            out_q <= 1'b0;
            upd_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
            upd_q <= upd_d;
        end
    end

    assign out = out_q;
    assign upd = upd_q;

`ifdef SW_DEBOUNCER_EDGE_EN
    logic rise_q, fall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= upd_d & in;
            fall_q <= upd_d & ~in;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: rtl/sw_debouncer.sv
// Slide-switch bus synchroniser plus per-bit debouncer; changed pulses when any bit updates.
// Per-bit rise/fall pulses are generated only when SW_DEBOUNCER_EDGE_EN is defined.
module sw_debouncer
    import sw_debounce_pkg::*;
#(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic             changed,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] sync0_q, sync1_q;
    logic [WIDTH-1:0] upd;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync0_q <= '0;
            sync1_q <= '0;
        end else begin
            sync0_q <= sw_in;
            sync1_q <= sync0_q;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_bit (
            .clk (clk),
            .rst (rst),
            .in  (sync1_q[i]),
            .out (sw_out[i]),
            .upd (upd[i]),
            .rise(rise[i]),
            .fall(fall[i])
        );
    end

    // Strobes are already registered, so the OR lines up with the sw_out update.
    assign changed = |upd;

endmodule

// File: tb/tb_sw_debouncer.sv
// Randomised and directed bench for sw_debouncer against a sliding-window reference model.
module tb_sw_debouncer;
    import sw_debounce_pkg::*;

    localparam int unsigned W  = 8;
    localparam int unsigned SC = SIM_STABLE_CYCLES;
`ifdef SW_DEBOUNCER_EDGE_EN
    localparam bit EdgeEn = 1'b1;
`else
    localparam bit EdgeEn = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] sw_in = '0;
    logic [W-1:0] sw_out, rise, fall;
    logic         changed;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    sw_debouncer #(
        .WIDTH        (W),
        .STABLE_CYCLES(SC)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .sw_in  (sw_in),
        .sw_out (sw_out),
        .changed(changed),
        .rise   (rise),
        .fall   (fall)
    );

    always #5 clk = ~clk;

    // Model: a bit flips once the last SC synchronised samples all disagree with it.
    logic [W-1:0] m_s0 = '0, m_s1 = '0, m_out = '0, m_rise = '0, m_fall = '0;
    logic         m_chg = 1'b0;
    logic [W-1:0] win[$];
    logic [W-1:0] seen, nr, nf;
    bit           all_diff;

    always @(posedge clk) begin
        if (rst) begin
            m_s0 = '0; m_s1 = '0; m_out = '0;
            m_rise = '0; m_fall = '0; m_chg = 1'b0;
            win.delete();
        end else begin
            seen = m_s1;
            win.push_back(seen);
            if (win.size() > SC) void'(win.pop_front());
            nr = '0; nf = '0;
            if (win.size() == SC) begin
                for (int b = 0; b < W; b++) begin
                    all_diff = 1'b1;
                    foreach (win[j]) if (win[j][b] == m_out[b]) all_diff = 1'b0;
                    if (all_diff) begin
                        if (m_out[b]) nf[b] = 1'b1;
                        else          nr[b] = 1'b1;
                    end
                end
            end
            m_out  = (m_out | nr) & ~nf;
            m_chg  = |(nr | nf);
            m_rise = EdgeEn ? nr : '0;
            m_fall = EdgeEn ? nf : '0;
            m_s1 = m_s0;
            m_s0 = sw_in;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("cyc_sw_out", 32'(sw_out), 32'(m_out));
            chk("cyc_changed", 32'(changed), 32'(m_chg));
            chk("cyc_rise", 32'(rise), 32'(m_rise));
            chk("cyc_fall", 32'(fall), 32'(m_fall));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    int chg_cnt;

    initial begin
        cyc(3);
        rst = 1'b0;
        check_en = 1'b1;
        chk("reset_sw_out", 32'(sw_out), 32'h0);
        chk("reset_changed", 32'(changed), 32'h0);
        chk("reset_model", 32'(m_out), 32'h0);

        // Idle hold.
        chg_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (changed) chg_cnt++;
        end
        chk("idle_sw_out", 32'(sw_out), 32'h00);
        chk("idle_changes", 32'(chg_cnt), 32'd0);

        // Three-cycle glitch on bit 0 is rejected.
        sw_in = 8'h01;
        cyc(3);
        sw_in = 8'h00;
        chg_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            if (changed) chg_cnt++;
        end
        chk("glitch_sw_out", 32'(sw_out), 32'h00);
        chk("glitch_changes", 32'(chg_cnt), 32'd0);
        chk("glitch_model", 32'(m_out), 32'h00);

        // Clean 00->80: visible after edge k+5 only.
        sw_in = 8'h80;
        cyc(5);
        chk("lat_before", 32'(sw_out), 32'h00);
        cyc(1);
        chk("lat_sw_out", 32'(sw_out), 32'h80);
        chk("lat_changed", 32'(changed), 32'h1);
        chk("lat_rise", 32'(rise), EdgeEn ? 32'h80 : 32'h0);
        chk("lat_model", 32'(m_out), 32'h80);
        cyc(1);
        chk("lat_changed_off", 32'(changed), 32'h0);
        chk("lat_rise_off", 32'(rise), 32'h0);

        sw_in = 8'h00;
        cyc(10);
        chk("back_zero", 32'(sw_out), 32'h00);

        // Two bits updating together give one changed pulse.
        sw_in = 8'h81;
        chg_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            if (changed) chg_cnt++;
        end
        chk("multi_sw_out", 32'(sw_out), 32'h81);
        chk("multi_rise", 32'(rise), EdgeEn ? 32'h81 : 32'h0);
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            if (changed) chg_cnt++;
        end
        chk("multi_pulses", 32'(chg_cnt), 32'd1);

        // Reset mid-operation with switches held high.
        sw_in = 8'hFF;
        cyc(10);
        chk("pre_rst_sw_out", 32'(sw_out), 32'hFF);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("rst_clear", 32'(sw_out), 32'h00);
        cyc(5);
        chk("rst_still_low", 32'(sw_out), 32'h00);
        cyc(1);
        chk("rst_recover", 32'(sw_out), 32'hFF);
        chk("rst_rise", 32'(rise), EdgeEn ? 32'hFF : 32'h0);
        chk("rst_model", 32'(m_out), 32'hFF);

        // FF->00 falls on every bit.
        sw_in = 8'h00;
        cyc(6);
        chk("fall_sw_out", 32'(sw_out), 32'h00);
        chk("fall_changed", 32'(changed), 32'h1);
        chk("fall_fall", 32'(fall), EdgeEn ? 32'hFF : 32'h0);
        chk("fall_rise", 32'(rise), 32'h0);

        // Random phase: bursts of holds, bit flips and occasional resets.
        for (int s = 0; s < 400; s++) begin
            case ($urandom_range(0, 9))
                0:       sw_in = W'($urandom);
                1:       begin rst = 1'b1; cyc(1); rst = 1'b0; end
                default: sw_in = sw_in ^ W'(1 << $urandom_range(0, W - 1));
            endcase
            cyc($urandom_range(1, 2 * SC + 2));
        end
        cyc(2 * SC + 4);

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
